// File: rtl/mem_perf_pkg.sv
// Shared types and constants for the mem_system performance monitor.
package mem_perf_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int ERR_HIT_LAT   = 0;
  localparam int ERR_MISS_LAT  = 1;
  localparam int ERR_DROP      = 2;
  localparam int ERR_TIMEOUT   = 3;
  localparam int ERR_RDWR      = 4;
  localparam int ERR_SPUR_DONE = 5;
  localparam int ERR_W         = 6;

endpackage

// File: rtl/mem_perf_satcnt.sv
// Saturating up-counter with a variable increment; clamps at all-ones instead of wrapping.
module mem_perf_satcnt #(
  parameter int W  = 32,
  parameter int IW = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [IW-1:0] amt_i,
  output logic [W-1:0]  cnt_o
);

  // Sum is wide enough for both operands so a large increment never truncates.
  localparam int SW = ((W > IW) ? W : IW) + 1;

  logic [W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0] sum;

  always_comb begin
    sum   = SW'(cnt_q) + SW'(amt_i);
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (|sum[SW-1:W]) ? '1 : sum[W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_perf_monitor.sv
// Passive latency/throughput monitor for the mem_system request/response interface.
//   state   | meaning
//   ST_IDLE | no request outstanding, watching for Rd/Wr issue
//   ST_BUSY | one request in flight, latency counter running
module mem_perf_monitor
  import mem_perf_pkg::*;
#(
  parameter int AW       = 16,
  parameter int CW       = 32,
  parameter int LW       = 8,
  parameter int HIT_MAX  = 2,
  parameter int MISS_MIN = 2,
  parameter int MISS_MAX = 20,
  parameter int TIMEOUT  = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          Rd,
  input  logic          Wr,
  input  logic [AW-1:0] Addr,
  input  logic          Done,
  input  logic          Stall,
  input  logic          CacheHit,
  output logic          busy,
  output logic [LW-1:0] last_lat,
  output logic [LW-1:0] max_lat,
  output logic [CW-1:0] n_req,
  output logic [CW-1:0] n_rep,
  output logic [CW-1:0] n_hit,
  output logic [CW-1:0] n_rd,
  output logic [CW-1:0] n_wr,
  output logic [CW-1:0] n_stall,
  output logic [CW-1:0] lat_sum,
  output logic [5:0]    err
);

  state_e          state_q, state_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0]   last_q, last_d, max_q, max_d;
  logic [ERR_W-1:0] err_q, err_d, err_set;

  logic            issue, cpl;
  logic [LW-1:0]   cpl_lat;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    issue   = 1'b0;
    cpl     = 1'b0;
    cpl_lat = lat_q;
    err_set = '0;

    case (state_q)
      ST_IDLE: begin
        if (en && (Rd || Wr)) begin
          issue  = 1'b1;
          rd_d   = Rd;
          wr_d   = Wr;
          addr_d = Addr;
          if (Rd && Wr) err_set[ERR_RDWR] = 1'b1;
          if (Done) begin
            cpl     = 1'b1;
            cpl_lat = '0;
          end else begin
            state_d = ST_BUSY;
            lat_d   = LW'(1);
          end
        end else if (en && Done) begin
          err_set[ERR_SPUR_DONE] = 1'b1;
        end
      end
      ST_BUSY: begin
        if (Done) begin
          cpl     = 1'b1;
          state_d = ST_IDLE;
          lat_d   = '0;
        end else if ((Rd != rd_q) || (Wr != wr_q) || (Addr != addr_q)) begin
          err_set[ERR_DROP] = 1'b1;
          state_d           = ST_IDLE;
          lat_d             = '0;
        end else if (lat_q == LW'(TIMEOUT - 1)) begin
          err_set[ERR_TIMEOUT] = 1'b1;
          state_d              = ST_IDLE;
          lat_d                = '0;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        lat_d   = '0;
      end
    endcase

    if (cpl) begin
      if (CacheHit) begin
        if (cpl_lat > LW'(HIT_MAX)) err_set[ERR_HIT_LAT] = 1'b1;
      end else if ((cpl_lat <= LW'(MISS_MIN)) || (cpl_lat > LW'(MISS_MAX))) begin
        err_set[ERR_MISS_LAT] = 1'b1;
      end
    end
    err_d = err_q | err_set;
  end

  // Latency statistics freeze with the counters while the monitor is disabled.
  always_comb begin
    last_d = last_q;
    max_d  = max_q;
    if (cpl && en) begin
      last_d = cpl_lat;
      if (cpl_lat > max_q) max_d = cpl_lat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      last_q  <= '0;
      max_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      last_q  <= last_d;
      max_q   <= max_d;
      err_q   <= err_d;
    end
  end

  mem_perf_satcnt #(.W(CW), .IW(1)) u_req (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en && issue),
    .amt_i(1'b1), .cnt_o(n_req)
  );

  mem_perf_satcnt #(.W(CW), .IW(1)) u_rep (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en && cpl),
    .amt_i(1'b1), .cnt_o(n_rep)
  );

  mem_perf_satcnt #(.W(CW), .IW(1)) u_hit (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en && cpl && CacheHit),
    .amt_i(1'b1), .cnt_o(n_hit)
  );

  // Rd&Wr together is counted as a read only.
  mem_perf_satcnt #(.W(CW), .IW(1)) u_rd (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en && issue && Rd),
    .amt_i(1'b1), .cnt_o(n_rd)
  );

  mem_perf_satcnt #(.W(CW), .IW(1)) u_wr (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en && issue && Wr && !Rd),
    .amt_i(1'b1), .cnt_o(n_wr)
  );

  mem_perf_satcnt #(.W(CW), .IW(1)) u_stall (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en && Stall),
    .amt_i(1'b1), .cnt_o(n_stall)
  );

  mem_perf_satcnt #(.W(CW), .IW(LW)) u_lat_sum (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .en_i(en && cpl),
    .amt_i(cpl_lat), .cnt_o(lat_sum)
  );

  assign busy     = (state_q == ST_BUSY);
  assign last_lat = last_q;
  assign max_lat  = max_q;
  assign err      = err_q;

endmodule
